// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
//   Shared constants for the pipeline stall/flush controller: stall/reset
//   polarities, the four legal stall-bus patterns, the multi-cycle FSM state
//   encodings and the stall-pattern priority selector.
package pipe_stall_ctrl_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NOSTOP     = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    // stall[0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

    // Highest-priority request wins; a flush overrides every stall so the
    // flushed registers actually load their bubble this cycle.
    function automatic logic [5:0] stall_sel(input logic flush_req,
                                             input logic mem_req,
                                             input logic ex_req,
                                             input logic id_req);
        logic [5:0] s;
        s = STALL_NONE;
        if (flush_req)    s = STALL_NONE;
        else if (mem_req) s = STALL_MEM;
        else if (ex_req)  s = STALL_EX;
        else if (id_req)  s = STALL_ID;
        return s;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// sat_counter
//   Saturating up-counter used for the stall-cycle performance count.
//   Ports: clk, rst (sync, active-high), inc (count this cycle),
//          clear (sync clear), count [PERF_W-1:0] (holds at all-ones).
module sat_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clear,
    output logic [PERF_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush controller for the 6-stage core. Arbitrates stall
//   requests from ID/EX/MEM, sequences multi-cycle EX operations and counts
//   stalled cycles.
//   Ports:
//     clk, rst                      clock, sync active-high reset
//     stallreq_from_id/ex/mem       per-stage stall requests
//     ex_multi_start                EX holds a multi-cycle op (sampled in IDLE)
//     ex_multi_cycles [CYC_W-1:0]   op length N (0 treated as 1)
//     flush_req                     exception/eret flush request
//     stall [5:0]                   per-register stall bus, 1 = stop
//     flush                         flush all pipeline registers
//     multi_busy / multi_done       FSM in BUSY / result valid
//     stall_cnt [PERF_W-1:0]        saturating count of cycles with stall[0]
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned CYC_W  = 6,
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_from_id,
    input  logic              stallreq_from_ex,
    input  logic              stallreq_from_mem,
    input  logic              ex_multi_start,
    input  logic [CYC_W-1:0]  ex_multi_cycles,
    input  logic              flush_req,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              multi_busy,
    output logic              multi_done,
    output logic [PERF_W-1:0] stall_cnt
);

    mc_state_t        state, state_nxt;
    logic [CYC_W-1:0] cnt, cnt_nxt;
    logic             ex_stall;
    logic             in_rst;

    assign in_rst = (rst == RST_ENABLE);

    // The start cycle itself stalls EX so the op stays in id_ex while BUSY.
    always_comb begin
        ex_stall = stallreq_from_ex
                 | ((state == MC_IDLE) & ex_multi_start)
                 | (state == MC_BUSY);
    end

    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        multi_busy = 1'b0;
        multi_done = 1'b0;
        if (!in_rst) begin
            stall      = stall_sel(flush_req, stallreq_from_mem, ex_stall,
                                   stallreq_from_id);
            flush      = flush_req;
            multi_busy = (state == MC_BUSY);
            multi_done = (state == MC_DONE) & ~flush_req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_req) begin
            state_nxt = MC_IDLE;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (ex_multi_start) begin
                        cnt_nxt   = (ex_multi_cycles == '0) ? CYC_W'(1)
                                                            : ex_multi_cycles;
                        state_nxt = MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    // Counts down independent of stalls: the unit runs free.
                    cnt_nxt = cnt - CYC_W'(1);
                    if (cnt == CYC_W'(1)) begin
                        state_nxt = MC_DONE;
                    end
                end
                MC_DONE: begin
                    // Hold the result until EX can actually latch it.
                    if (stall[3] == NOSTOP) begin
                        state_nxt = MC_IDLE;
                    end
                end
                default: state_nxt = MC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    sat_counter #(
        .PERF_W(PERF_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall[0]),
        .clear(1'b0),
        .count(stall_cnt)
    );

endmodule
